// File: rtl/gsplat_pkg.sv
// Shared definitions for the splat tile pipeline: tile geometry, the
// tile-buffer word layout, the u0.10 -> u8 channel conversion and the 2x2
// Bayer dither table.
package gsplat_pkg;

    localparam int unsigned TILE_W = 32;
    localparam int unsigned TILE_H = 32;
    localparam int unsigned TX_W   = $clog2(TILE_W);
    localparam int unsigned TY_W   = $clog2(TILE_H);
    localparam int unsigned IDX_W  = TX_W + TY_W;

    // Tile-buffer word: {A,B,G,R}, 16 bits per channel, u0.10 in the low bits.
    localparam int unsigned CH_W     = 16;
    localparam int unsigned FRAC_W   = 10;
    localparam int unsigned CH_R_LSB = 0;
    localparam int unsigned CH_G_LSB = 16;
    localparam int unsigned CH_B_LSB = 32;
    localparam int unsigned CH_A_LSB = 48;
    localparam int unsigned TB_WORD_W = 4 * CH_W;

    // Framebuffer pixel payload {A8,B8,G8,R8}.
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } px_rgba8_t;

    // Ordered 2x2 Bayer offsets indexed by {sy[0],sx[0]}: {0,2,3,1}.
    localparam logic [7:0] BAYER_TBL = {2'd1, 2'd3, 2'd2, 2'd0};

    function automatic logic [1:0] bayer_d(input logic sy0, input logic sx0);
        return BAYER_TBL[2 * int'({sy0, sx0}) +: 2];
    endfunction

    // Saturate any integer bits to 1023, add the dither offset, keep the top
    // 8 bits of the 10-bit fraction and clamp at 255.
    function automatic logic [7:0] tb_ch_to_u8(input logic [CH_W-1:0] ch,
                                               input logic [1:0]      d);
        logic [FRAC_W-1:0] v;
        logic [FRAC_W:0]   s;
        v = (|ch[CH_W-1:FRAC_W]) ? '1 : ch[FRAC_W-1:0];
        s = {1'b0, v} + {{(FRAC_W-1){1'b0}}, d};
        return s[FRAC_W] ? 8'hFF : s[FRAC_W-1:2];
    endfunction

endpackage

// File: rtl/tile_resolver_if.sv
// Framebuffer-writer stream: pixel address + RGBA8 data over valid/ready.
//   master: drives fb_valid, fb_addr, fb_data; receives fb_ready
//   slave : the FB writer side
interface tile_resolver_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              fb_valid;
    logic              fb_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic [31:0]       fb_data;

    modport master (output fb_valid, output fb_addr, output fb_data, input fb_ready);
    modport slave  (input fb_valid, input fb_addr, input fb_data, output fb_ready);
endinterface

// File: rtl/resolve_out_fifo.sv
// Two-entry output FIFO of {fb_addr, fb_data} beats.
//   clk, reset  : clock, synchronous active-high reset (flushes contents)
//   push, din   : write a beat (legal when full if a pop happens the same cycle)
//   ready       : downstream accept; a pop is valid && ready
//   valid, head : oldest beat, held stable until popped
//   count       : occupancy, used by the read-credit logic
module resolve_out_fifo #(
    parameter int unsigned W = 51
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop;

    assign valid = (count != 2'd0);
    assign pop   = valid & ready;
    assign head  = mem[rd_ptr];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/tile_resolver.sv
// Tile resolver: scans the 32x32 tile buffer in raster order, converts each
// u0.10 RGBA entry to RGBA8, streams on-screen pixels with framebuffer
// addresses to the FB writer and clears every entry right after reading it.
//   clk, reset           : clock, synchronous active-high reset
//   start, tile_px/py    : begin a tile; origin latched on start
//   busy, done           : busy from the cycle after start; done 1-cycle pulse
//   tb_rd_addr/tb_rd_data: tile-buffer read port, 1-cycle latency
//   tb_wr_addr/data/en   : clear-write port (data always zero)
//   fb                   : pixel stream to the FB writer (master)
// Optional build macro TILE_RESOLVER_DITHER_EN: 2x2 ordered dither on R,G,B.
module tile_resolver
    import gsplat_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = 640,
    parameter int unsigned FB_HEIGHT = 480,
    parameter int unsigned FB_ADDR_W = 19
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [15:0]          tile_px,
    input  logic [15:0]          tile_py,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     tb_rd_addr,
    input  logic [TB_WORD_W-1:0] tb_rd_data,
    output logic [IDX_W-1:0]     tb_wr_addr,
    output logic [TB_WORD_W-1:0] tb_wr_data,
    output logic                 tb_wr_en,
    tile_resolver_if.master      fb
);
    localparam int unsigned BEAT_W = FB_ADDR_W + 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] scan_idx;
    logic [15:0]      tile_px_q;
    logic [15:0]      tile_py_q;

    logic [1:0]       fifo_count;
    logic             fifo_valid;
    logic [BEAT_W-1:0] fifo_head;

    logic             pop_c;
    logic [2:0]       credit_c;
    logic             issue_c;
    logic [16:0]      sx_c;
    logic [16:0]      sy_c;
    logic             on_screen_c;
    logic             push_c;
    logic [1:0]       dith_c;
    px_rgba8_t        pix_c;
    logic [FB_ADDR_W-1:0] fb_addr_c;

    // The RAM reads whatever address is presented, so the scan counter is the
    // read address; tb_wr_en/tb_wr_addr double as the returning-read tag.
    assign tb_rd_addr = scan_idx;
    assign tb_wr_data = '0;

    // Read credit: FIFO occupancy after this cycle's pop plus the read whose
    // data is returning now must leave room, so a full-rate stream holds.
    assign pop_c    = fifo_valid & fb.fb_ready;
    assign credit_c = {1'b0, fifo_count - {1'b0, pop_c}} + {2'b0, tb_wr_en};
    assign issue_c  = (state == S_SCAN) && (credit_c < 3'd2);

    // Returned pixel: screen coordinates, clipping and framebuffer address.
    assign sx_c        = {1'b0, tile_px_q} + 17'(tb_wr_addr[TX_W-1:0]);
    assign sy_c        = {1'b0, tile_py_q} + 17'(tb_wr_addr[IDX_W-1:TX_W]);
    assign on_screen_c = (sx_c < 17'(FB_WIDTH)) && (sy_c < 17'(FB_HEIGHT));
    assign push_c      = tb_wr_en & on_screen_c;
    assign fb_addr_c   = FB_ADDR_W'(32'(sy_c) * 32'(FB_WIDTH) + 32'(sx_c));

`ifdef TILE_RESOLVER_DITHER_EN
    assign dith_c = bayer_d(sy_c[0], sx_c[0]);
`else
    assign dith_c = 2'd0;
`endif

    // Channel conversion; alpha never takes the dither offset.
    always_comb begin
        pix_c   = '0;
        pix_c.r = tb_ch_to_u8(tb_rd_data[CH_R_LSB +: CH_W], dith_c);
        pix_c.g = tb_ch_to_u8(tb_rd_data[CH_G_LSB +: CH_W], dith_c);
        pix_c.b = tb_ch_to_u8(tb_rd_data[CH_B_LSB +: CH_W], dith_c);
        pix_c.a = tb_ch_to_u8(tb_rd_data[CH_A_LSB +: CH_W], 2'd0);
    end

    resolve_out_fifo #(
        .W (BEAT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .din   ({fb_addr_c, pix_c}),
        .ready (fb.fb_ready),
        .valid (fifo_valid),
        .head  (fifo_head),
        .count (fifo_count)
    );

    assign fb.fb_valid = fifo_valid;
    assign fb.fb_addr  = fifo_head[BEAT_W-1:32];
    assign fb.fb_data  = fifo_head[31:0];

    // Control FSM, scan counter and clear-write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_idx   <= '0;
            tb_wr_en   <= 1'b0;
            tb_wr_addr <= '0;
            tile_px_q  <= '0;
            tile_py_q  <= '0;
        end else begin
            done     <= 1'b0;
            tb_wr_en <= issue_c;
            if (issue_c) begin
                tb_wr_addr <= scan_idx;
                scan_idx   <= scan_idx + IDX_W'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_SCAN;
                        busy      <= 1'b1;
                        scan_idx  <= '0;
                        tile_px_q <= tile_px;
                        tile_py_q <= tile_py;
                    end
                end
                S_SCAN: begin
                    if (issue_c && (scan_idx == '1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tb_wr_en && (fifo_count == 2'd0)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tile_resolver.sv
module tb_tile_resolver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] tile_px = '0;
    logic [15:0] tile_py = '0;
    logic        busy;
    logic        done;
    logic [9:0]  tb_rd_addr;
    logic [63:0] tb_rd_data = '0;
    logic [9:0]  tb_wr_addr;
    logic [63:0] tb_wr_data;
    logic        tb_wr_en;

    int checks = 0;
    int passed = 0;
    int collisions = 0;
    int stab_err = 0;

    logic [63:0] tmem [1024];
    logic [50:0] got_q [$];
    logic        prev_stall = 1'b0;
    logic [50:0] prev_beat = '0;

    tile_resolver_if #(.ADDR_W(19)) fb_if ();

    tile_resolver #(
        .FB_WIDTH  (640),
        .FB_HEIGHT (480),
        .FB_ADDR_W (19)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tile_px    (tile_px),
        .tile_py    (tile_py),
        .busy       (busy),
        .done       (done),
        .tb_rd_addr (tb_rd_addr),
        .tb_rd_data (tb_rd_data),
        .tb_wr_addr (tb_wr_addr),
        .tb_wr_data (tb_wr_data),
        .tb_wr_en   (tb_wr_en),
        .fb         (fb_if.master)
    );

    always #5 clk = ~clk;

    // Tile-buffer RAM model, 1-cycle read latency; counts read/clear collisions.
    always @(posedge clk) begin
        tb_rd_data <= tmem[tb_rd_addr];
        if (tb_wr_en) tmem[tb_wr_addr] <= tb_wr_data;
        if (tb_wr_en && (tb_wr_addr == tb_rd_addr)) collisions++;
    end

    // FB writer monitor: capture accepted beats, check stability while stalled.
    always @(negedge clk) begin
        if (prev_stall && !reset &&
            (!fb_if.fb_valid || ({fb_if.fb_addr, fb_if.fb_data} != prev_beat)))
            stab_err++;
        if (fb_if.fb_valid && fb_if.fb_ready && !reset)
            got_q.push_back({fb_if.fb_addr, fb_if.fb_data});
        prev_stall = fb_if.fb_valid && !fb_if.fb_ready && !reset;
        prev_beat  = {fb_if.fb_addr, fb_if.fb_data};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic int conv(input int ch, input int d);
        int v;
        int r;
        v = (ch > 1023) ? 1023 : ch;
        r = (v + d) / 4;
        return (r > 255) ? 255 : r;
    endfunction

    // Reference: every tile entry in raster order, clipped to the screen.
    function automatic void build_expected(input int px, input int py, output logic [50:0] q [$]);
        int bay [4] = '{0, 2, 3, 1};
        q.delete();
        for (int i = 0; i < 1024; i++) begin
            int sx, sy, d, addr;
            logic [63:0] w;
            logic [31:0] data;
            sx = px + (i % 32);
            sy = py + (i / 32);
            if (sx < 640 && sy < 480) begin
                w = tmem[i];
                d = 0;
`ifdef TILE_RESOLVER_DITHER_EN
                d = bay[(sy % 2) * 2 + (sx % 2)];
`endif
                addr = (sy * 640 + sx) % 524288;
                data = {8'(conv(int'(w[63:48]), 0)), 8'(conv(int'(w[47:32]), d)),
                        8'(conv(int'(w[31:16]), d)), 8'(conv(int'(w[15:0]), d))};
                q.push_back({19'(addr), data});
            end
        end
    endfunction

    function automatic logic [15:0] rnd_ch();
        return ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1023));
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 1024; i++)
            tmem[i] = {rnd_ch(), rnd_ch(), rnd_ch(), rnd_ch()};
    endtask

    task automatic fill_const(input logic [63:0] w);
        for (int i = 0; i < 1024; i++) tmem[i] = w;
    endtask

    task automatic run_tile(input int px, input int py, input bit rnd, input bit poke,
                            input bit chk_lat, input string name);
        logic [50:0] exp_q [$];
        int cyc;
        int nz;
        build_expected(px, py, exp_q);
        got_q.delete();
        @(posedge clk); #1;
        start = 1'b1; tile_px = 16'(px); tile_py = 16'(py); fb_ready_set(1'b1);
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
        while (!done && cyc < 5000) begin
            fb_ready_set(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            if (poke && cyc == 50) begin
                start = 1'b1; tile_px = 16'd0; tile_py = 16'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        fb_ready_set(1'b1);
        chk({name, "_done_pulse"}, 64'(done), 64'd1);
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        if (chk_lat) chk({name, "_latency"}, 64'(cyc >= 1024 && cyc <= 1032), 64'd1);
        @(posedge clk); #1;
        chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({name, "_npix"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_pix%0d", name, i), 64'(got_q[i]), 64'(exp_q[i]));
        nz = 0;
        for (int i = 0; i < 1024; i++) if (tmem[i] != 64'd0) nz++;
        chk({name, "_cleared"}, 64'(nz), 64'd0);
        chk({name, "_no_collision"}, 64'(collisions), 64'd0);
        chk({name, "_stable_when_stalled"}, 64'(stab_err), 64'd0);
    endtask

    task automatic fb_ready_set(input logic v);
        fb_if.fb_ready = v;
    endtask

    initial begin
        logic [50:0] b;
        fb_ready_set(1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_fb_valid", 64'(fb_if.fb_valid), 64'd0);
        chk("rst_wr_en", 64'(tb_wr_en), 64'd0);
        chk("rst_rd_addr", 64'(tb_rd_addr), 64'd0);
        chk("rst_wr_addr", 64'(tb_wr_addr), 64'd0);
        chk("rst_wr_data", tb_wr_data, 64'd0);
        chk("rst_fb_addr", 64'(fb_if.fb_addr), 64'd0);
        chk("rst_fb_data", 64'(fb_if.fb_data), 64'd0);
        reset = 1'b0;

        // Constant tile at the origin, full-rate sink.
        fill_const({16'd1023, 16'd4, 16'd512, 16'd1020});
        run_tile(0, 0, 1'b0, 1'b0, 1'b1, "const");
        b = got_q[0];
        chk("const_data0", 64'(b[31:0]), 64'h0000_0000_FF01_80FF);
        b = got_q[32];
        chk("const_addr32", 64'(b[50:32]), 64'd640);

        // Random data, random back-pressure, stray start while busy.
        fill_random();
        run_tile(64, 96, 1'b1, 1'b1, 1'b0, "rand");

        // Bottom-right corner tile: only the on-screen quarter is streamed.
        fill_random();
        run_tile(624, 464, 1'b1, 1'b0, 1'b0, "clip");
        chk("clip_count", 64'(got_q.size()), 64'd256);

        // Integer-bit overflow saturates.
        fill_random();
        tmem[0] = {16'd0, 16'd0, 16'd0, 16'h0400};
        run_tile(128, 0, 1'b1, 1'b0, 1'b0, "ovf");
        b = got_q[0];
        chk("ovf_r8", 64'(b[7:0]), 64'hFF);

`ifdef TILE_RESOLVER_DITHER_EN
        fill_const({16'd1023, 16'd0, 16'd2, 16'd1});
        run_tile(0, 0, 1'b0, 1'b0, 1'b0, "dith");
        b = got_q[33];
        chk("dith_r_1_1", 64'(b[7:0]), 64'd0);
        b = got_q[1];
        chk("dith_r_1_0", 64'(b[7:0]), 64'd0);
        chk("dith_g_1_0", 64'(b[15:8]), 64'd1);
`endif

        // Reset 100 cycles into a scan, then a clean full tile.
        fill_random();
        @(posedge clk); #1;
        start = 1'b1; tile_px = 16'd32; tile_py = 16'd32;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (99) @(posedge clk);
        #1;
        chk("mid_busy_before_reset", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_fb_valid", 64'(fb_if.fb_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        fill_random();
        run_tile(32, 32, 1'b1, 1'b0, 1'b0, "after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
